// File: rtl/ringosc_freq_counter.sv
// ringosc_freq_counter: counts oscillator rising edges per gate window; define FREQ_HOLD_EN to defer publication to frame_sync
module ringosc_freq_counter #(
    parameter int GATE_CYCLES = 25000,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ena_i,
    input  logic             osc_in_i,
    input  logic             frame_sync_i,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             overflow_o
);
    localparam int GW = $clog2(GATE_CYCLES);
    typedef enum logic {WARMUP, RUN} state_t;
    state_t state_q;
    logic [2:0] sync_q;
    logic [GW-1:0] gate_q;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic sat_q, sat_d, rise, wclose, full;
    assign rise = sync_q[1] & ~sync_q[2];
    assign wclose = gate_q == GW'(GATE_CYCLES - 1);
    assign full = &edge_q;
    assign edge_d = edge_q + CNT_W'(rise & ~full);
    assign sat_d = sat_q | (rise & full);
`ifdef FREQ_HOLD_EN
    logic pend_q;
    logic [CNT_W-1:0] pend_cnt_q;
    logic pend_ovf_q;
`else
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync_i;
`endif
    // three-stage synchronizer for the asynchronous oscillator tap
    always_ff @(posedge clk_i) begin
        sync_q <= reset_i ? '0 : {sync_q[1:0], osc_in_i};
    end
    // gate window, edge accumulation and result publication
    always_ff @(posedge clk_i) begin
        if (reset_i || !ena_i) begin
            gate_q <= '0;
            edge_q <= '0;
            sat_q <= 1'b0;
            state_q <= WARMUP;
            count_valid_o <= 1'b0;
            if (reset_i) begin
                count_o <= '0;
                overflow_o <= 1'b0;
            end
`ifdef FREQ_HOLD_EN
            pend_q <= 1'b0;
            pend_cnt_q <= '0;
            pend_ovf_q <= 1'b0;
`endif
        end else begin
            count_valid_o <= 1'b0;
            gate_q <= wclose ? '0 : gate_q + GW'(1);
            edge_q <= wclose ? '0 : edge_d;
            sat_q <= wclose ? 1'b0 : sat_d;
            if (wclose) state_q <= RUN;
`ifdef FREQ_HOLD_EN
            if (wclose && state_q == RUN) begin
                if (frame_sync_i) begin
                    count_o <= edge_d;
                    overflow_o <= sat_d;
                    count_valid_o <= 1'b1;
                    pend_q <= 1'b0;
                end else begin
                    pend_q <= 1'b1;
                    pend_cnt_q <= edge_d;
                    pend_ovf_q <= sat_d;
                end
            end else if (frame_sync_i && pend_q) begin
                count_o <= pend_cnt_q;
                overflow_o <= pend_ovf_q;
                count_valid_o <= 1'b1;
                pend_q <= 1'b0;
            end
`else
            if (wclose && state_q == RUN) begin
                count_o <= edge_d;
                overflow_o <= sat_d;
                count_valid_o <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ringosc_freq_counter.sv
// tb_ringosc_freq_counter: random and directed stimulus against a window-arithmetic reference model
module tb_ringosc_freq_counter;
    localparam int G = 100;
    logic clk = 1'b0;
    logic reset_i = 1'b1, ena_i = 1'b0, osc_in_i = 1'b0, frame_sync_i = 1'b0;
    logic [15:0] cnt16;
    logic [3:0] cnt4;
    logic v16, v4, o16, o4;
    int checks = 0, errors = 0;
    int n = 0, r = 0, acc = 0, p_acc = 0, period = 10, phase = 0;
    int det_q[$];
    bit prev_x = 0, pend = 0, e_valid = 0, e_o16 = 0, e_o4 = 0;
    int e_c16 = 0, e_c4 = 0;

    always #5 clk = ~clk;

    ringosc_freq_counter #(.GATE_CYCLES(G), .CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .ena_i(ena_i), .osc_in_i(osc_in_i),
        .frame_sync_i(frame_sync_i), .count_o(cnt16), .count_valid_o(v16), .overflow_o(o16));
    ringosc_freq_counter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .ena_i(ena_i), .osc_in_i(osc_in_i),
        .frame_sync_i(frame_sync_i), .count_o(cnt4), .count_valid_o(v4), .overflow_o(o4));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, got, exp, n);
        end
    endtask

    // a window's published value: raw edge total saturated to the result width
    task automatic publish(int a);
        e_valid = 1;
        e_c16 = a > 65535 ? 65535 : a;
        e_o16 = a > 65535;
        e_c4 = a > 15 ? 15 : a;
        e_o4 = a > 15;
    endtask

    function automatic bit oscv();
        return ((n + phase) % period) < (period / 2);
    endfunction

    function automatic bit fsv();
        return (n % 350) == 0;
    endfunction

    // one clk cycle: drive inputs, advance the model for the coming edge, check after the edge
    task automatic step(bit rst, bit en, bit x, bit fs);
        int hits;
        @(negedge clk);
        reset_i = rst; ena_i = en; osc_in_i = x; frame_sync_i = fs;
        e_valid = 0;
        hits = 0;
        if (rst) begin
            r = 0; acc = 0; prev_x = 0; pend = 0;
            det_q.delete();
            e_c16 = 0; e_c4 = 0; e_o16 = 0; e_o4 = 0;
        end else begin
            while (det_q.size() > 0 && det_q[0] == n) begin
                void'(det_q.pop_front());
                hits++;
            end
            if (x && !prev_x) det_q.push_back(n + 2);
            prev_x = x;
            if (!en) begin
                r = 0; acc = 0; pend = 0;
            end else begin
                acc += hits;
`ifdef FREQ_HOLD_EN
                if (r % G == G - 1 && r >= 2 * G - 1) begin
                    if (fs) begin publish(acc); pend = 0; end
                    else begin pend = 1; p_acc = acc; end
                end else if (fs && pend) begin
                    publish(p_acc);
                    pend = 0;
                end
`else
                if (r % G == G - 1 && r >= 2 * G - 1) publish(acc);
`endif
                if (r % G == G - 1) acc = 0;
                r++;
            end
        end
        n++;
        @(posedge clk);
        #1;
        chk("valid16", 32'(v16), 32'(e_valid));
        chk("count16", 32'(cnt16), 32'(e_c16));
        chk("ovf16", 32'(o16), 32'(e_o16));
        chk("valid4", 32'(v4), 32'(e_valid));
        chk("count4", 32'(cnt4), 32'(e_c4));
        chk("ovf4", 32'(o4), 32'(e_o4));
    endtask

    initial begin
        repeat (3) step(1, 1, 0, 0);
        chk("reset_count", 32'(cnt16), 0);
        chk("reset_valid", 32'(v16), 0);
        chk("reset_ovf", 32'(o16), 0);
        // period 10: first publication at cycle 200
        period = 10;
        for (int i = 0; i < 200; i++) step(0, 1, oscv(), fsv());
`ifndef FREQ_HOLD_EN
        chk("t1_valid200", 32'(v16), 1);
        chk("t1_count200", 32'(cnt16), 10);
`endif
        for (int i = 0; i < 200; i++) step(0, 1, oscv(), fsv());
        // period 4: 25 edges saturate the 4-bit counter
        period = 4;
        for (int i = 0; i < 300; i++) step(0, 1, oscv(), fsv());
`ifndef FREQ_HOLD_EN
        chk("t3_count4", 32'(cnt4), 15);
        chk("t3_ovf4", 32'(o4), 1);
        chk("t3_count16", 32'(cnt16), 25);
`endif
        period = 10;
        for (int i = 0; i < 200; i++) step(0, 1, oscv(), fsv());
`ifndef FREQ_HOLD_EN
        chk("t3b_count4", 32'(cnt4), 10);
        chk("t3b_ovf4", 32'(o4), 0);
`endif
        // ena drop: count holds, fresh warmup after re-enable
        for (int i = 0; i < 50; i++) step(0, 1, oscv(), fsv());
        for (int i = 0; i < 20; i++) step(0, 0, oscv(), fsv());
        chk("t4_hold", 32'(cnt16), 10);
        for (int i = 0; i < 200; i++) step(0, 1, oscv(), fsv());
`ifndef FREQ_HOLD_EN
        chk("t4_valid_after_reen", 32'(v16), 1);
`endif
        // reset mid-window
        for (int i = 0; i < 50; i++) step(0, 1, oscv(), fsv());
        step(1, 1, oscv(), fsv());
        chk("t5_count", 32'(cnt16), 0);
        chk("t5_ovf", 32'(o4), 0);
        for (int i = 0; i < 200; i++) step(0, 1, oscv(), fsv());
`ifndef FREQ_HOLD_EN
        chk("t5_valid200", 32'(v16), 1);
`endif
        // single pulse detected on the last gate cycle of window 1
        step(1, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, i >= 197 && i <= 201, fsv());
`ifndef FREQ_HOLD_EN
            if (i == 199) chk("t2_closing", 32'(cnt16), 1);
            if (i == 299) chk("t2_next", 32'(cnt16), 0);
`endif
        end
        // random segments
        for (int s = 0; s < 25; s++) begin
            int kind, len;
            period = int'($urandom_range(4, 24));
            phase = int'($urandom_range(0, 23));
            kind = int'($urandom_range(0, 5));
            len = int'($urandom_range(50, 400));
            if (kind == 0) begin
                for (int i = 0; i < len / 10; i++) step(0, 0, oscv(), fsv());
            end else begin
                if (kind == 1) step(1, 1, oscv(), fsv());
                for (int i = 0; i < len; i++) step(0, 1, oscv(), fsv());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
